aes_inv_key_schedule: RTL

- Decryption-side companion to the AES-128 forward key expansion.
- Produces the eleven round keys in reverse order, round 10 down to round 0, one key per valid/ready handshake, for the inverse cipher datapath.
- Accepts either the cipher key or the final (round-10) key:
  - Cipher key: the block first runs the forward expansion internally for 10 cycles, then walks backwards.
  - Final key: it walks backwards immediately.

---
 rtl/aes_inv_key_schedule.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/aes_inv_key_schedule.sv
// AES-128 inverse key schedule: emits round keys 10 down to 0 over a
// valid/ready handshake, starting from either the cipher key (forward
// expansion runs internally first) or the round-10 key.
module aes_inv_key_schedule #(
   parameter int unsigned NR = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] key_in,
   input  logic         key_is_last,
   output logic         busy,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk_out,
   output logic [3:0]   rk_round,
   output logic         done
);

   localparam int unsigned KW = 128;
   localparam int unsigned WW = 32;
   localparam logic [3:0]  LAST = 4'(NR);

   typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   // SubWord(RotWord(w))
   function automatic logic [WW-1:0] sub_rot(input logic [WW-1:0] w);
      return {SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]], SBOX[w[31:24]]};
   endfunction

   // Round constant in the top byte; zero outside rounds 1..10
   function automatic logic [WW-1:0] rcon(input logic [3:0] r);
      logic [7:0] b;
      case (r)
         4'd1:    b = 8'h01;
         4'd2:    b = 8'h02;
         4'd3:    b = 8'h04;
         4'd4:    b = 8'h08;
         4'd5:    b = 8'h10;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h40;
         4'd8:    b = 8'h80;
         4'd9:    b = 8'h1b;
         4'd10:   b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h0};
   endfunction

   state_t          state;
   logic [3:0]      cnt;
   logic [KW-1:0]   fwd_key;
   logic [KW-1:0]   inv_key;
   logic [WW-1:0]   w0, w1, w2, w3;
   logic [WW-1:0]   f0, f1, f2, f3;
   logic [WW-1:0]   i0, i1, i2, i3;

   // Forward and inverse single-round steps on the key register
   always_comb begin
      w0 = rk_out[127:96];
      w1 = rk_out[95:64];
      w2 = rk_out[63:32];
      w3 = rk_out[31:0];
      f0 = w0 ^ sub_rot(w3) ^ rcon(cnt);
      f1 = w1 ^ f0;
      f2 = w2 ^ f1;
      f3 = w3 ^ f2;
      i3 = w3 ^ w2;
      i2 = w2 ^ w1;
      i1 = w1 ^ w0;
      i0 = w0 ^ sub_rot(i3) ^ rcon(rk_round);
      fwd_key = {f0, f1, f2, f3};
      inv_key = {i0, i1, i2, i3};
   end

   // Control FSM; rk_out doubles as the key register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         busy     <= 1'b0;
         rk_valid <= 1'b0;
         rk_out   <= '0;
         rk_round <= 4'd0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  rk_out <= key_in;
                  busy   <= 1'b1;
                  if (key_is_last) begin
                     rk_round <= LAST;
                     rk_valid <= 1'b1;
                     state    <= EMIT;
                  end else begin
                     cnt   <= 4'd1;
                     state <= FWD;
                  end
               end
            end
            FWD: begin
               rk_out <= fwd_key;
               cnt    <= cnt + 4'd1;
               if (cnt == LAST) begin
                  rk_round <= LAST;
                  rk_valid <= 1'b1;
                  state    <= EMIT;
               end
            end
            EMIT: begin
               if (rk_ready) begin
                  if (rk_round != 4'd0) begin
                     rk_out   <= inv_key;
                     rk_round <= rk_round - 4'd1;
                  end else begin
                     rk_valid <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     state    <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
